// File: rtl/autotest_pkg.sv
// Shared types and constants for the autotest result-capture path.
// Holds the capture FSM states, status bit positions and record layout.
package autotest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CAPTURE,
        EMIT,
        DONE
    } capture_state_t;

    // Bit positions inside the record status byte.
    localparam int END_BIT     = 0;
    localparam int ERR_BIT     = 1;
    localparam int SAT_BIT     = 2;
    localparam int TIMEOUT_BIT = 3;

    localparam int RECORD_HDR_BYTES = 6;
    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // RUN cycles during which stale synchronized flags are ignored.
    localparam int RUN_BLANK_CYCLES = 2;

    function automatic int record_len(input int output_size);
        return RECORD_HDR_BYTES + output_size / 8;
    endfunction

endpackage

// File: rtl/uut_result_capture_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, asynchronous active-low reset.
// Ports: clk, rst (active-low), d (async input), q (synchronized output).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uut_result_capture.sv
// uut_result_capture: runs one UUT measurement, counts clk cycles until the
// UUT finishes, then streams a fixed-length byte record (valid/ready).
// Ports: clk, rst (async active-low), arm (start pulse), rst_uut (UUT reset),
//   end_uut/err_uut (async UUT flags), output_from_UUT (UUT result),
//   byte_data/byte_valid/byte_ready (record stream), busy, done (pulse).
// Optional: define UUT_TIMEOUT_EN to abort RUN after TIMEOUT_CYCLES.
// Record: MAGIC, status, counter[31:0] MSB first, captured output MSB first.
module uut_result_capture
    import autotest_pkg::*;
#(
    parameter int          OUTPUT_SIZE    = 32,
    parameter int          CNT_WIDTH      = 32,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    output logic                   rst_uut,
    input  logic                   end_uut,
    input  logic                   err_uut,
    input  logic [OUTPUT_SIZE-1:0] output_from_UUT,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int NBYTES = record_len(OUTPUT_SIZE);
    localparam int OBYTES = OUTPUT_SIZE / 8;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    if (CNT_WIDTH != 32) begin : g_cnt_chk
        $error("uut_result_capture: CNT_WIDTH must be 32");
    end
    if (OUTPUT_SIZE < 8 || (OUTPUT_SIZE % 8) != 0) begin : g_out_chk
        $error("uut_result_capture: OUTPUT_SIZE must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES == 32'd0) begin : g_tmo_chk
        $error("uut_result_capture: TIMEOUT_CYCLES must be nonzero");
    end

    capture_state_t state;
    capture_state_t state_nx;

    logic                   end_s;
    logic                   err_s;
    logic [CNT_WIDTH-1:0]   count;
    logic [OUTPUT_SIZE-1:0] captured;
    logic [7:0]             status;
    logic [7:0]             st_cap;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_nx;
    logic [7:0]             rec [NBYTES];
    logic [7:0]             next_byte;
    logic                   accept;
    logic                   blank_done;
    logic                   flag_hit;
    logic                   timeout_hit;
    logic                   to_flag;
    logic                   stop;

    sync_2ff u_sync_end (
        .clk (clk),
        .rst (rst),
        .d   (end_uut),
        .q   (end_s)
    );

    sync_2ff u_sync_err (
        .clk (clk),
        .rst (rst),
        .d   (err_uut),
        .q   (err_s)
    );

    // count is cleared on arm and only advances in RUN, so it doubles as
    // the RUN age used to mask the synchronizer's stale pipeline contents.
    assign blank_done = (count >= CNT_WIDTH'(RUN_BLANK_CYCLES));
    assign flag_hit   = blank_done && (end_s || err_s);
    assign accept     = byte_valid && byte_ready;
    assign idx_nx     = idx + 1'b1;

`ifdef UUT_TIMEOUT_EN
    assign timeout_hit = (count == CNT_WIDTH'(TIMEOUT_CYCLES));

    // Remembers why RUN ended; the flags are re-sampled in CAPTURE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_flag <= 1'b0;
        end else if (state == IDLE) begin
            to_flag <= 1'b0;
        end else if (state == RUN) begin
            to_flag <= timeout_hit && !flag_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_flag     = 1'b0;
`endif

    assign stop = flag_hit || timeout_hit;

    always_comb begin
        st_cap              = '0;
        st_cap[END_BIT]     = end_s;
        st_cap[ERR_BIT]     = err_s;
        st_cap[SAT_BIT]     = &count;
        st_cap[TIMEOUT_BIT] = to_flag;
    end

    always_comb begin
        rec[0] = MAGIC;
        rec[1] = status;
        for (int i = 0; i < 4; i++) begin
            rec[2 + i] = count[8 * (3 - i) +: 8];
        end
        for (int i = 0; i < OBYTES; i++) begin
            rec[RECORD_HDR_BYTES + i] = captured[8 * (OBYTES - 1 - i) +: 8];
        end
    end

    assign next_byte = (idx == LAST_IDX) ? 8'h00 : rec[idx_nx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rst_uut  = 1'b1;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (arm) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                rst_uut = 1'b0;
                if (stop) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                // UUT stays out of reset so its output is still valid here.
                rst_uut  = 1'b0;
                state_nx = EMIT;
            end
            EMIT: begin
                if (accept && idx == LAST_IDX) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            captured   <= '0;
            status     <= '0;
            idx        <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        count <= '0;
                    end
                end
                RUN: begin
                    // Frozen on the exit cycle; saturates instead of wrapping.
                    if (!stop && !(&count)) begin
                        count <= count + 1'b1;
                    end
                end
                CAPTURE: begin
                    captured   <= output_from_UUT;
                    status     <= st_cap;
                    idx        <= '0;
                    byte_data  <= MAGIC;
                    byte_valid <= 1'b1;
                end
                EMIT: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            byte_valid <= 1'b0;
                            byte_data  <= '0;
                        end else begin
                            idx       <= idx_nx;
                            byte_data <= next_byte;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uut_result_capture.sv
// Self-checking bench for uut_result_capture.
// Randomized runs scored against a record model built from the byte layout.
module tb_uut_result_capture;

    localparam int OSZ = 32;
    localparam int NB  = 6 + OSZ / 8;
    localparam logic [31:0] TMO = 32'd50;
`ifdef UUT_TIMEOUT_EN
    localparam int K_MAX    = 45;
    localparam int NORMAL_K = 40;
`else
    localparam int K_MAX    = 120;
    localparam int NORMAL_K = 98;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           arm = 1'b0;
    logic           rst_uut;
    logic           end_uut = 1'b0;
    logic           err_uut = 1'b0;
    logic [OSZ-1:0] output_from_UUT = '0;
    logic [7:0]     byte_data;
    logic           byte_valid;
    logic           byte_ready = 1'b0;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_fail   = 0;

    uut_result_capture #(
        .OUTPUT_SIZE    (OSZ),
        .CNT_WIDTH      (32),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .arm             (arm),
        .rst_uut         (rst_uut),
        .end_uut         (end_uut),
        .err_uut         (err_uut),
        .output_from_UUT (output_from_UUT),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // k: posedges after RUN entry before the flags are raised.
    // rmode: 0 always ready, 1 random, 2 pattern 1,0,0,1.
    task automatic measure(input int k, input bit e, input bit r,
                           input logic [31:0] data, input int rmode,
                           input bit stale, input bit rearm,
                           input int abort_at, input bit tmo);
        logic [7:0]  exp_q[$];
        logic [7:0]  exp_b;
        logic [7:0]  held;
        logic [31:0] cnt_exp;
        logic [7:0]  st_exp;
        int          accepted;
        int          pat;
        bit          pend;
        bit          seen_done;
        bit          last_final;
        bit          aborted;

        // Flags seen two synchronizer stages late; that cycle is not counted.
        cnt_exp = tmo ? TMO : 32'(k + 2);
        st_exp  = tmo ? 8'h08 : {6'b0, r, e};
        exp_q.push_back(8'hA5);
        exp_q.push_back(st_exp);
        for (int i = 3; i >= 0; i--) exp_q.push_back(cnt_exp[8*i +: 8]);
        for (int i = OSZ/8 - 1; i >= 0; i--) exp_q.push_back(data[8*i +: 8]);

        output_from_UUT = data;
        byte_ready = 1'b0;
        if (stale) begin
            end_uut = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        if (stale) end_uut = 1'b0;
        @(negedge clk);
        check("rst_uut_run", 32'(rst_uut), 32'd0);
        check("busy_run", 32'(busy), 32'd1);

        if (!tmo) begin
            for (int c = 1; c <= k; c++) begin
                @(posedge clk); #1;
                arm = rearm && (c == k / 2);
            end
            arm = 1'b0;
            check("still_run", 32'(rst_uut), 32'd0);
            end_uut = e;
            err_uut = r;
        end

        accepted = 0; pat = 0; pend = 0; seen_done = 0;
        last_final = 0; aborted = 0; held = '0;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            @(posedge clk); #1;
            case (rmode)
                0: byte_ready = 1'b1;
                1: byte_ready = 1'($urandom_range(0, 1));
                default: byte_ready = (pat % 4 == 0) || (pat % 4 == 3);
            endcase
            pat++;
            @(negedge clk);
            if (pend) begin
                check("stall_valid", 32'(byte_valid), 32'd1);
                check("stall_data", 32'(byte_data), 32'(held));
            end
            if (done) begin
                check("done_after_last", 32'(last_final), 32'd1);
                check("rec_len", 32'(accepted), 32'(NB));
                seen_done = 1;
            end
            last_final = 0;
            if (byte_valid) check("rst_uut_emit", 32'(rst_uut), 32'd1);
            pend = byte_valid && !byte_ready;
            held = byte_data;
            if (byte_valid && byte_ready) begin
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check($sformatf("byte%0d", accepted), 32'(byte_data),
                          32'(exp_b));
                end else begin
                    check("extra_byte", 32'(accepted + 1), 32'(NB));
                end
                accepted++;
                last_final = (accepted == NB);
                if (abort_at != 0 && accepted == abort_at) begin
                    aborted = 1;
                    break;
                end
            end
        end

        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            check("abort_valid", 32'(byte_valid), 32'd0);
            check("abort_rst_uut", 32'(rst_uut), 32'd1);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            end_uut = 1'b0;
            err_uut = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("abort_no_done", 32'(done), 32'd0);
            end
            check("abort_idle", 32'(busy), 32'd0);
        end else begin
            if (!seen_done) check("done_timeout", 32'd0, 32'd1);
            end_uut = 1'b0;
            err_uut = 1'b0;
            byte_ready = 1'b0;
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(byte_valid), 32'd0);
            check("idle_rst_uut", 32'(rst_uut), 32'd1);
        end
    endtask

    initial begin
        int  k;
        bit  e;
        bit  r;
        int  sel;

        #1;
        check("rst_rst_uut", 32'(rst_uut), 32'd1);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_data", 32'(byte_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'd0);

        measure(NORMAL_K, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        measure(10, 1, 1, 32'h12345678, 0, 0, 0, 0, 0);
        measure(20, 1, 0, 32'hCAFEF00D, 2, 0, 0, 0, 0);
        measure(15, 1, 0, 32'h0BADC0DE, 0, 1, 1, 0, 0);
        measure(12, 0, 1, 32'h55AA33CC, 0, 0, 0, 3, 0);
        measure(7, 0, 1, 32'hA1B2C3D4, 1, 0, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            k   = $urandom_range(3, K_MAX);
            sel = $urandom_range(0, 2);
            e   = (sel != 1);
            r   = (sel != 0);
            measure(k, e, r, $urandom, 1, 0, 1'($urandom_range(0, 1)),
                    0, 0);
        end

`ifdef UUT_TIMEOUT_EN
        measure(0, 0, 0, 32'h87654321, 0, 0, 0, 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
